// File: rtl/sample_feeder_if.sv
// Sample stream interface between an acquisition source and sample_feeder.
// The source drives data/valid; the feeder answers with ready.
interface sample_feeder_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sample_feeder.sv
// sample_feeder: buffers raw samples in a small FIFO and hands them to an
// integrator at a programmable interval, after a programmable number of
// warm-up strobes.
// Optional build macro UNDERRUN_HOLD_EN: when defined, signal_input keeps its
// previous value on an underrun strobe; otherwise it is cleared to zero.
module sample_feeder #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                resetb,
  sample_feeder_if.slave      in_if,
  input  logic                enable,
  input  logic [7:0]          period,
  input  logic [3:0]          warmup,
  output logic [DATA_W-1:0]   signal_input,
  output logic                start_integration,
  output logic                sample_strobe,
  output logic                underrun,
  output logic [LW-1:0]       level
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  state_t            state_reg;
  state_t            state_next;
  logic [7:0]        cnt_reg;
  logic [7:0]        cnt_next;
  logic [3:0]        wcnt_reg;
  logic [3:0]        wcnt_next;
  logic [4:0]        wcnt_inc;
  logic              active;
  logic              strobe_fire;
  logic              push;
  logic              pop;
  logic              underrun_fire;
  logic              ready_en_reg;
  logic              start_integration_reg;
  logic              sample_strobe_reg;
  logic              underrun_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic [LW-1:0]     level_next;
  logic [DATA_W-1:0] signal_input_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  // Ready comes from the registered level only, so a full FIFO refuses a
  // push even when a pop happens in the same cycle.
  assign in_if.ready = ready_en_reg && (level_reg != FULL_LEVEL);

  assign push          = in_if.valid && in_if.ready;
  // A push into an empty FIFO is never forwarded to a same-cycle pop.
  assign pop           = strobe_fire && (level_reg != '0);
  assign underrun_fire = strobe_fire && (level_reg == '0);
  assign wcnt_inc      = {1'b0, wcnt_reg} + 5'd1;

  // Next-state, interval counter and warm-up counter decode.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    wcnt_next   = wcnt_reg;
    active      = (state_reg != IDLE) && enable;
    // >= keeps the counter from running away if period is lowered mid-interval.
    strobe_fire = active && (cnt_reg >= period);

    if (!active) begin
      cnt_next = '0;
    end else if (strobe_fire) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 8'd1;
    end

    case (state_reg)
      IDLE: begin
        wcnt_next = '0;
        if (enable) begin
          state_next = WARMUP;
        end
      end
      WARMUP: begin
        if (!enable) begin
          state_next = IDLE;
          wcnt_next  = '0;
        end else if (warmup == 4'd0) begin
          state_next = RUN;
        end else if (strobe_fire) begin
          wcnt_next = wcnt_inc[3:0];
          if (wcnt_inc >= {1'b0, warmup}) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (!enable) begin
          state_next = IDLE;
          wcnt_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        wcnt_next  = '0;
      end
    endcase
  end

  // FIFO occupancy update for push, pop or both.
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // Control state: FSM, counters and the registered RUN indicator.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_reg             <= IDLE;
      cnt_reg               <= '0;
      wcnt_reg              <= '0;
      start_integration_reg <= 1'b0;
    end else begin
      state_reg             <= state_next;
      cnt_reg               <= cnt_next;
      wcnt_reg              <= wcnt_next;
      start_integration_reg <= (state_next == RUN);
    end
  end

  // One-cycle strobe and underrun pulses.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sample_strobe_reg <= 1'b0;
      underrun_reg      <= 1'b0;
    end else begin
      sample_strobe_reg <= strobe_fire;
      underrun_reg      <= underrun_fire;
    end
  end

  // FIFO pointers, level and the post-reset ready enable.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      level_reg    <= level_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  // Sample storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_if.data;
    end
  end

  // Registered read of the FIFO head into the integrator input.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      signal_input_reg <= '0;
    end else if (pop) begin
      signal_input_reg <= mem[rd_ptr_reg];
    end else if (underrun_fire) begin
`ifdef UNDERRUN_HOLD_EN
      signal_input_reg <= signal_input_reg;
`else
      signal_input_reg <= '0;
`endif
    end
  end

  assign signal_input      = signal_input_reg;
  assign start_integration = start_integration_reg;
  assign sample_strobe     = sample_strobe_reg;
  assign underrun          = underrun_reg;
  assign level             = level_reg;

endmodule

// File: tb/tb_sample_feeder.sv
// Self-checking bench for sample_feeder: reset, a table-driven fill test,
// hand-written multi-cycle sequences, then randomized traffic against a
// queue-based reference model.
`ifndef N
`define N 16
`endif

module tb_sample_feeder;
  localparam int DW    = `N;
  localparam int DEPTH = 8;
  localparam int LW    = 4;
`ifdef UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetb;
  logic          enable;
  logic [7:0]    period;
  logic [3:0]    warmup;
  logic [DW-1:0] signal_input;
  logic          start_integration;
  logic          sample_strobe;
  logic          underrun;
  logic [LW-1:0] level;

  int checks   = 0;
  int failures = 0;

  sample_feeder_if #(.DATA_W(DW)) bus ();

  sample_feeder #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .resetb            (resetb),
    .in_if             (bus),
    .enable            (enable),
    .period            (period),
    .warmup            (warmup),
    .signal_input      (signal_input),
    .start_integration (start_integration),
    .sample_strobe     (sample_strobe),
    .underrun          (underrun),
    .level             (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    int            exp_level;
    logic          exp_ready;
  } fill_vec_t;

  fill_vec_t fill_tab [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.valid = 1'b0;
    enable    = 1'b0;
    resetb    = 1'b0;
    tick();
    tick();
    resetb = 1'b1;
    tick();
  endtask

  task automatic push_one(input int value);
    bus.valid = 1'b1;
    bus.data  = DW'(value);
    tick();
    bus.valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int            k;
    int            exp_sig;
    int            m_mode;
    int            m_t;
    int            m_wc;
    int            rnd_strobes;
    bit            m_fire;
    bit            m_under;
    bit            m_push;
    logic [DW-1:0] m_out;
    logic [DW-1:0] mq [$];

    // Stimulus table for the fill test: nine pushes into an 8-entry FIFO,
    // then one idle cycle.
    for (int i = 0; i < 10; i++) begin
      fill_tab[i].valid     = (i < 9);
      fill_tab[i].data      = DW'(100 + i);
      fill_tab[i].exp_level = (i < 8) ? i + 1 : 8;
      fill_tab[i].exp_ready = (i < 7);
    end

    // ---------------- reset with a push attempt ----------------
    resetb    = 1'b1;
    enable    = 1'b0;
    period    = 8'd0;
    warmup    = 4'd0;
    bus.valid = 1'b1;
    bus.data  = DW'(5);
    #1 resetb = 1'b0;
    tick(); tick(); tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_signal", 32'(signal_input), 32'd0);
    check("rst_start", 32'(start_integration), 32'd0);
    check("rst_strobe", 32'(sample_strobe), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    bus.valid = 1'b0;
    resetb    = 1'b1;
    tick();
    check("post_rst_ready", 32'(bus.ready), 32'd1);
    check("post_rst_level", 32'(level), 32'd0);
    $display("reset test done level=%0d", level);

    // ---------------- table-driven fill to full ----------------
    for (int i = 0; i < 10; i++) begin
      bus.valid = fill_tab[i].valid;
      bus.data  = fill_tab[i].data;
      tick();
      check($sformatf("fill%0d_level", i), 32'(level), 32'(fill_tab[i].exp_level));
      check($sformatf("fill%0d_ready", i), 32'(bus.ready), 32'(fill_tab[i].exp_ready));
      $display("fill push valid=%0d data=%0d level=%0d", fill_tab[i].valid, fill_tab[i].data, level);
    end
    bus.valid = 1'b0;

    // Drain with period 0 / warmup 0: the rejected ninth sample must not appear.
    period = 8'd0;
    warmup = 4'd0;
    enable = 1'b1;
    tick();
    check("drain_first_strobe", 32'(sample_strobe), 32'd0);
    for (int j = 0; j < 8; j++) begin
      tick();
      check($sformatf("drain%0d_strobe", j), 32'(sample_strobe), 32'd1);
      check($sformatf("drain%0d_signal", j), 32'(signal_input), 32'(100 + j));
      check($sformatf("drain%0d_underrun", j), 32'(underrun), 32'd0);
      $display("drain strobe signal_input=%0d", signal_input);
    end
    tick();
    check("drain_underrun", 32'(underrun), 32'd1);
    check("drain_under_strobe", 32'(sample_strobe), 32'd1);
    check("drain_under_signal", 32'(signal_input), HOLD ? 32'd107 : 32'd0);
    $display("drain underrun signal_input=%0d", signal_input);
    enable = 1'b0;
    tick();
    do_reset();

    // ---------------- period 2, warmup 2 sequence ----------------
    push_one(2); push_one(4); push_one(6); push_one(8); push_one(10);
    period = 8'd2;
    warmup = 4'd2;
    enable = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      tick();
      k       = (e >= 3) ? e / 3 : 0;
      exp_sig = (k == 0) ? 0 : (k <= 5) ? 2 * k : (HOLD ? 10 : 0);
      check($sformatf("seq_e%0d_strobe", e), 32'(sample_strobe), 32'(e >= 3 && e % 3 == 0));
      check($sformatf("seq_e%0d_signal", e), 32'(signal_input), 32'(exp_sig));
      check($sformatf("seq_e%0d_start", e), 32'(start_integration), 32'(e >= 6));
      check($sformatf("seq_e%0d_underrun", e), 32'(underrun), 32'(e == 18));
      check($sformatf("seq_e%0d_level", e), 32'(level), 32'(5 - ((k > 5) ? 5 : k)));
      if (sample_strobe)
        $display("seq strobe e=%0d signal_input=%0d start=%0d underrun=%0d", e, signal_input, start_integration, underrun);
    end
    enable = 1'b0;
    tick();
    do_reset();

    // ---------------- period 0 with steady pushes ----------------
    push_one(1); push_one(2); push_one(3);
    period = 8'd0;
    warmup = 4'd0;
    enable = 1'b1;
    tick();
    check("p0_level_before", 32'(level), 32'd3);
    check("p0_strobe_before", 32'(sample_strobe), 32'd0);
    bus.valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      bus.data = DW'(4 + j);
      tick();
      check($sformatf("p0_%0d_strobe", j), 32'(sample_strobe), 32'd1);
      check($sformatf("p0_%0d_underrun", j), 32'(underrun), 32'd0);
      check($sformatf("p0_%0d_level", j), 32'(level), 32'd3);
      check($sformatf("p0_%0d_signal", j), 32'(signal_input), 32'(j + 1));
      $display("p0 strobe signal_input=%0d level=%0d", signal_input, level);
    end
    bus.valid = 1'b0;
    enable    = 1'b0;
    tick();
    do_reset();

    // ---------------- enable drop mid-interval, then reset ----------------
    for (int v = 10; v < 16; v++) push_one(v);
    period = 8'd3;
    warmup = 4'd1;
    enable = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      tick();
      if (e == 4) begin
        check("drop_e4_strobe", 32'(sample_strobe), 32'd1);
        check("drop_e4_start", 32'(start_integration), 32'd1);
        check("drop_e4_signal", 32'(signal_input), 32'd10);
      end
      if (e == 8) begin
        check("drop_e8_strobe", 32'(sample_strobe), 32'd1);
        check("drop_e8_level", 32'(level), 32'd4);
        check("drop_e8_signal", 32'(signal_input), 32'd11);
      end
    end
    enable = 1'b0;
    tick();
    check("drop_start", 32'(start_integration), 32'd0);
    check("drop_strobe", 32'(sample_strobe), 32'd0);
    check("drop_level", 32'(level), 32'd4);
    for (int j = 0; j < 6; j++) begin
      tick();
      check($sformatf("drop_idle%0d_strobe", j), 32'(sample_strobe), 32'd0);
    end
    check("drop_level_kept", 32'(level), 32'd4);
    $display("enable drop level=%0d start=%0d", level, start_integration);
    resetb = 1'b0;
    #1;
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_ready", 32'(bus.ready), 32'd0);
    tick();
    resetb = 1'b1;
    tick();
    $display("async reset level=%0d", level);

    // ---------------- randomized traffic vs reference model ----------------
    m_mode      = 0;
    m_t         = 0;
    m_wc        = 0;
    m_out       = '0;
    rnd_strobes = 0;
    mq.delete();
    enable = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (enable ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 20))
        enable = ~enable;
      if (!enable && $urandom_range(0, 3) == 0) begin
        period = 8'($urandom_range(0, 3));
        warmup = 4'($urandom_range(0, 3));
      end
      bus.valid = ($urandom_range(0, 99) < 45);
      bus.data  = DW'($urandom);

      // Model: strobes fall every (period+1) active cycles; pop precedes push.
      m_push  = bus.valid && (mq.size() < DEPTH);
      m_fire  = (m_mode != 0) && enable && ((m_t % (int'(period) + 1)) == int'(period));
      m_under = m_fire && (mq.size() == 0);
      if (m_fire) begin
        if (mq.size() > 0) m_out = mq.pop_front();
        else if (!HOLD)    m_out = '0;
      end
      if (m_push) mq.push_back(bus.data);
      if (!enable) begin
        m_mode = 0;
        m_t    = 0;
        m_wc   = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
        m_t    = 0;
      end else begin
        m_t++;
        if (m_mode == 1) begin
          if (warmup == 4'd0) begin
            m_mode = 2;
          end else if (m_fire) begin
            m_wc++;
            if (m_wc >= int'(warmup)) m_mode = 2;
          end
        end
      end

      tick();
      if (m_fire) rnd_strobes++;
      check($sformatf("rnd%0d_strobe", cyc), 32'(sample_strobe), 32'(m_fire));
      check($sformatf("rnd%0d_underrun", cyc), 32'(underrun), 32'(m_under));
      check($sformatf("rnd%0d_signal", cyc), 32'(signal_input), 32'(m_out));
      check($sformatf("rnd%0d_start", cyc), 32'(start_integration), 32'(m_mode == 2));
      check($sformatf("rnd%0d_level", cyc), 32'(level), 32'(mq.size()));
      check($sformatf("rnd%0d_ready", cyc), 32'(bus.ready), 32'(mq.size() < DEPTH));
    end
    $display("random phase strobes=%0d", rnd_strobes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter DATA_W, default 16, sample width; instantiated with the project `N width macro.
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetb  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  DATA_W  raw sample from acquisition source.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  FIFO can accept in_data this cycle.
REQ-008 enable  input  1  run request; low forces IDLE.
REQ-009 period  input  8  sample interval minus one, in clk cycles.
REQ-010 warmup  input  4  strobes to issue before integration starts.
REQ-011 signal_input  output  DATA_W  registered sample to integrator.
REQ-012 start_integration  output  1  level; high while integrator shall accumulate.
REQ-013 sample_strobe  output  1  one-cycle pulse when signal_input updates.
REQ-014 underrun  output  1  one-cycle pulse when strobe finds FIFO empty.
REQ-015 level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 FIFO: push when in_valid && in_ready; in_ready = (level != DEPTH), combinational from registered level.
REQ-017 FSM states IDLE, WARMUP, RUN; IDLE->WARMUP when enable=1; WARMUP->RUN on the strobe that brings the warmup count to warmup; warmup=0 -> WARMUP->RUN on next cycle without strobe; RUN and WARMUP -> IDLE when enable=0.
REQ-018 In IDLE: interval counter held at 0, no strobes, FIFO still accepts pushes, signal_input holds.
REQ-019 Interval counter counts 0..period in WARMUP/RUN; sample_strobe asserted in the cycle after the counter equals period; period=0 -> strobe every cycle.
REQ-020 On strobe with level>0: pop head, signal_input <= head in the same edge as sample_strobe assertion.
REQ-021 On strobe with level=0: underrun pulses with sample_strobe; signal_input per REQ-031.
REQ-022 Simultaneous push and pop: both occur, level unchanged; push into an empty FIFO is not bypassed to a same-cycle pop (underrun still reported).
REQ-023 Full FIFO with pop in the same cycle: in_ready still 0 (derived from registered level); no push.
REQ-024 start_integration = 1 exactly in RUN, registered; rises in the cycle RUN is entered.
REQ-025 enable falling mid-interval: next cycle IDLE, start_integration 0, counter and warmup count cleared, FIFO contents kept.
REQ-026 period and warmup sampled continuously; a change takes effect at the next counter comparison.
REQ-027 Read/write pointers wrap modulo DEPTH.

Reset
REQ-028 resetb low: FSM IDLE, FIFO empty (level 0, pointers 0), counters 0.
REQ-029 resetb low: signal_input 0, start_integration 0, sample_strobe 0, underrun 0, in_ready 0 while resetb low, 1 after release.
REQ-030 Reset assertion mid-operation discards FIFO contents immediately.

Configuration
REQ-031 Macro UNDERRUN_HOLD_EN: defined -> on underrun signal_input holds its previous value; undefined -> signal_input <= 0 on underrun.

Verification
REQ-032 Reset: resetb=0 with in_valid=1, in_data=5 -> level 0, signal_input 0, start_integration 0, no push.
REQ-033 Push 2,4,6,8,10; period=2, warmup=2, enable=1 -> strobes every 3 cycles, signal_input 2,4,6,8,10; start_integration rises with strobe carrying 4.
REQ-034 Push 9 samples into empty FIFO, DEPTH=8, enable=0 -> level 8, in_ready 0, 9th sample rejected and later not output.
REQ-035 RUN with FIFO empty, last output 10 -> underrun pulse; signal_input 10 with UNDERRUN_HOLD_EN, 0 without.
REQ-036 period=0, FIFO level 3, push every cycle -> strobe every cycle, level stays 3, no underrun.
REQ-037 enable dropped mid-interval in RUN with level 4 -> start_integration 0 next cycle, no further strobes, level 4 retained; resetb pulse then -> level 0.
